wb_data_ram: RTL

- Wishbone classic slave data memory: the responder end of the CPU data-side bus issued from the MEM stage via the bus interface.
- Accepts single read/write cycles with byte selects and inserts a configurable number of wait states.
- Returns ack/data so the master's stall request releases.
- Used as on-chip data RAM in simulation and FPGA builds.

---
 rtl/wb_data_ram.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/wb_data_ram.sv
// Wishbone classic slave data RAM with byte-lane writes and a fixed number of wait states.
// Optional macro WB_DATA_RAM_ADDR_CHECK_EN turns out-of-range addresses into wb_err_o responses.
module wb_data_ram #(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [31:0] wb_adr_i,
    input  logic [3:0]  wb_sel_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o
);

    localparam int unsigned Depth = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    logic [31:0] mem [Depth];

    state_e                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
    logic [3:0]              sel_q, sel_d;
    logic [31:0]             wdat_q, wdat_d;
    logic                    oor_q, oor_d;
    logic                    ack_q, ack_d;
    logic                    err_q, err_d;
    logic [31:0]             rdat_q, rdat_d;

    logic req;
    logic req_oor;
    logic unused_adr;

    assign req = wb_cyc_i & wb_stb_i;

`ifdef WB_DATA_RAM_ADDR_CHECK_EN
    assign req_oor = (wb_adr_i >> (ADDR_WIDTH + 2)) != 32'd0;
`else
    // Upper address bits ignored: the RAM aliases across the whole address space.
    assign req_oor = 1'b0;
`endif

    assign unused_adr = ^{wb_adr_i[1:0], wb_adr_i[31:ADDR_WIDTH+2]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        idx_d   = idx_q;
        sel_d   = sel_q;
        wdat_d  = wdat_q;
        oor_d   = oor_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        rdat_d  = '0;

        unique case (state_q)
            StIdle: begin
                if (req) begin
                    we_d   = wb_we_i;
                    idx_d  = wb_adr_i[ADDR_WIDTH+1:2];
                    sel_d  = wb_sel_i;
                    wdat_d = wb_dat_i;
                    oor_d  = req_oor;
                    if (WAIT_STATES == 0) begin
                        state_d = StResp;
                    end else begin
                        state_d = StWait;
                        cnt_d   = 4'(WAIT_STATES);
                    end
                end
            end
            StWait: begin
                // Master dropping cyc abandons the request: no write, no ack.
                if (!wb_cyc_i) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_q <= 4'd1) begin
                    state_d = StResp;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Response registers are loaded on entry to RESP so outputs come straight from flops.
        if (state_d == StResp) begin
            ack_d = !oor_d;
            err_d = oor_d;
            if (!we_d && !oor_d) begin
                rdat_d = mem[idx_d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            sel_q   <= '0;
            wdat_q  <= '0;
            oor_q   <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdat_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            idx_q   <= idx_d;
            sel_q   <= sel_d;
            wdat_q  <= wdat_d;
            oor_q   <= oor_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdat_q  <= rdat_d;
        end
    end

    // Write commits at the edge that ends the ack cycle; a reset at that edge cancels it.
    always_ff @(posedge clk) begin
        if (rst && state_q == StResp && we_q && !oor_q) begin
            for (int b = 0; b < 4; b++) begin
                if (sel_q[b]) begin
                    mem[idx_q][8*b +: 8] <= wdat_q[8*b +: 8];
                end
            end
        end
    end

    assign wb_dat_o = rdat_q;
    assign wb_ack_o = ack_q;
    assign wb_err_o = err_q;

endmodule
